// File: rtl/display_source_arbiter.sv
// rtl/display_source_arbiter.sv - picks base, overlay or alert content for the 8-digit scanner
//
// Three requesters share the display, lowest to highest priority:
//   base    : live player status, passed straight through
//   overlay : one-shot popup latched on ovl_req, shown for HOLD_CYC cycles
//   alert   : latched message, blinks until alert_clr
// All outputs are registered; they follow the inputs/state one clock later.
//
// Optional feature: define DISPLAY_ARB_LZB_EN to blank leading zero digits
// of the base source (digits 7..1, stopping at the first nonzero nibble or
// lit decimal point). Undefined: base_en passes through unchanged.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   base_hex   in   [31:0] base digits, nibble k -> digit k (k=0 rightmost)
//   base_dp    in   [7:0]  base decimal points, 1 = lit
//   base_en    in   [7:0]  base digit enables, active low
//   ovl_req    in   pulse: latch ovl_hex/ovl_dp, (re)start hold timer
//   ovl_hex    in   [31:0] overlay digits
//   ovl_dp     in   [7:0]  overlay decimal points
//   alert_req  in   pulse: latch alert_hex, enter alert mode
//   alert_hex  in   [31:0] alert digits
//   alert_clr  in   pulse: leave alert mode
//   hex_out    out  [31:0] digits to the scanner
//   dp_out     out  [7:0]  decimal points to the scanner
//   digit_en   out  [7:0]  digit-enable mask, active low
//   src        out  [1:0]  00 base, 01 overlay, 10 alert
//   ovl_active out  overlay hold timer running

module display_source_arbiter #(
  parameter int HOLD_CYC  = 100000000,
  parameter int BLINK_CYC = 25000000,
  parameter int CNT_W     = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] base_hex,
  input  logic [7:0]  base_dp,
  input  logic [7:0]  base_en,
  input  logic        ovl_req,
  input  logic [31:0] ovl_hex,
  input  logic [7:0]  ovl_dp,
  input  logic        alert_req,
  input  logic [31:0] alert_hex,
  input  logic        alert_clr,
  output logic [31:0] hex_out,
  output logic [7:0]  dp_out,
  output logic [7:0]  digit_en,
  output logic [1:0]  src,
  output logic        ovl_active
);

  typedef enum logic [1:0] {
    S_BASE  = 2'b00,
    S_OVL   = 2'b01,
    S_ALERT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_d;
  logic             ovl_active_d;
  logic             blink_on, blink_on_d;
  logic [31:0]      ovl_hex_q, ovl_hex_d;
  logic [7:0]       ovl_dp_q, ovl_dp_d;
  logic [31:0]      alert_hex_q, alert_hex_d;
  logic [31:0]      hex_d;
  logic [7:0]       dp_d, en_d;
  logic [7:0]       base_en_eff;

`ifdef DISPLAY_ARB_LZB_EN
  logic [7:0] lzb_mask;
  logic       lzb_stop;

  always_comb begin
    lzb_mask = 8'h00;
    lzb_stop = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      if (!lzb_stop && base_hex[4*k +: 4] == 4'h0 && !base_dp[k]) begin
        lzb_mask[k] = 1'b1;
      end else begin
        lzb_stop = 1'b1;
      end
    end
  end

  assign base_en_eff = base_en | lzb_mask;
`else
  assign base_en_eff = base_en;
`endif

  // Hold timer runs in every state, so an overlay requested during an alert
  // keeps ageing in the background. A request on the expiry cycle reloads.
  always_comb begin
    hold_cnt_d   = hold_cnt;
    ovl_active_d = ovl_active;
    ovl_hex_d    = ovl_hex_q;
    ovl_dp_d     = ovl_dp_q;
    if (ovl_req) begin
      hold_cnt_d   = HOLD_LOAD;
      ovl_active_d = 1'b1;
      ovl_hex_d    = ovl_hex;
      ovl_dp_d     = ovl_dp;
    end else if (ovl_active) begin
      if (hold_cnt == '0) begin
        ovl_active_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt - CNT_W'(1);
      end
    end
  end

  // Next-state uses the next timer status so leaving an alert never lands in
  // S_OVL on the very cycle the overlay expires.
  always_comb begin
    state_d = state;
    case (state)
      S_BASE: begin
        if (alert_req)    state_d = S_ALERT;
        else if (ovl_req) state_d = S_OVL;
      end
      S_OVL: begin
        if (alert_req)          state_d = S_ALERT;
        else if (!ovl_active_d) state_d = S_BASE;
      end
      S_ALERT: begin
        if (alert_clr && !alert_req) state_d = ovl_active_d ? S_OVL : S_BASE;
      end
      default: state_d = S_BASE;
    endcase
  end

  // Blink counter only advances while staying in alert; entering alert or a
  // fresh alert_req restarts it at phase on.
  always_comb begin
    alert_hex_d = alert_req ? alert_hex : alert_hex_q;
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (state == S_ALERT && state_d == S_ALERT && !alert_req) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on;
      end else begin
        blink_cnt_d = blink_cnt + CNT_W'(1);
        blink_on_d  = blink_on;
      end
    end
  end

  // Output mux keyed on the next state so outputs lag inputs by one clock.
  always_comb begin
    hex_d = base_hex;
    dp_d  = base_dp;
    en_d  = base_en_eff;
    case (state_d)
      S_OVL: begin
        hex_d = ovl_hex_d;
        dp_d  = ovl_dp_d;
        en_d  = 8'h00;
      end
      S_ALERT: begin
        hex_d = alert_hex_d;
        dp_d  = 8'h00;
        en_d  = blink_on_d ? 8'h00 : 8'hFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BASE;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      ovl_active  <= 1'b0;
      ovl_hex_q   <= 32'h0;
      ovl_dp_q    <= 8'h00;
      alert_hex_q <= 32'h0;
      hex_out     <= 32'h0;
      dp_out      <= 8'h00;
      digit_en    <= 8'hFF;
      src         <= 2'b00;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_cnt_d;
      blink_cnt   <= blink_cnt_d;
      blink_on    <= blink_on_d;
      ovl_active  <= ovl_active_d;
      ovl_hex_q   <= ovl_hex_d;
      ovl_dp_q    <= ovl_dp_d;
      alert_hex_q <= alert_hex_d;
      hex_out     <= hex_d;
      dp_out      <= dp_d;
      digit_en    <= en_d;
      src         <= state_d;
    end
  end

endmodule

// File: tb/tb_display_source_arbiter.sv
// tb/tb_display_source_arbiter.sv - directed self-checking bench for display_source_arbiter
//
// DUT built with HOLD_CYC=10, BLINK_CYC=4, CNT_W=8. Inputs change 1 ns after
// a rising edge; outputs are checked at that same point, reflecting the edge.

module tb_display_source_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] base_hex = 32'h0;
  logic [7:0]  base_dp = 8'h00;
  logic [7:0]  base_en = 8'h00;
  logic        ovl_req = 1'b0;
  logic [31:0] ovl_hex = 32'h0;
  logic [7:0]  ovl_dp = 8'h00;
  logic        alert_req = 1'b0;
  logic [31:0] alert_hex = 32'h0;
  logic        alert_clr = 1'b0;
  logic [31:0] hex_out;
  logic [7:0]  dp_out;
  logic [7:0]  digit_en;
  logic [1:0]  src;
  logic        ovl_active;

  int checks = 0;
  int errors = 0;

  display_source_arbiter #(.HOLD_CYC(10), .BLINK_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .base_hex(base_hex), .base_dp(base_dp), .base_en(base_en),
    .ovl_req(ovl_req), .ovl_hex(ovl_hex), .ovl_dp(ovl_dp),
    .alert_req(alert_req), .alert_hex(alert_hex), .alert_clr(alert_clr),
    .hex_out(hex_out), .dp_out(dp_out), .digit_en(digit_en),
    .src(src), .ovl_active(ovl_active)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    base_hex = 32'h1234_5678; base_dp = 8'h04; base_en = 8'h00;
    repeat (3) tick();
    checks++;
    if (digit_en !== 8'hFF || src !== 2'b00 || hex_out !== 32'h0 || dp_out !== 8'h00 || ovl_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: en=%h src=%b hex=%h dp=%h act=%b, want en=ff src=00 hex=0 dp=0 act=0",
               digit_en, src, hex_out, dp_out, ovl_active);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (hex_out !== 32'h1234_5678 || dp_out !== 8'h04 || digit_en !== 8'h00 || src !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: hex=%h dp=%h en=%h src=%b, want hex=12345678 dp=04 en=00 src=00",
               hex_out, dp_out, digit_en, src);
    end
  endtask

  task automatic test_overlay_hold;
    ovl_hex = 32'h0000_0050; ovl_dp = 8'h02; ovl_req = 1'b1;
    tick();
    ovl_req = 1'b0;
    checks++;
    if (src !== 2'b01 || hex_out !== 32'h50 || dp_out !== 8'h02 || digit_en !== 8'h00 || ovl_active !== 1'b1) begin
      errors++;
      $display("FAIL ovl_start: src=%b hex=%h dp=%h en=%h act=%b, want src=01 hex=50 dp=02 en=00 act=1",
               src, hex_out, dp_out, digit_en, ovl_active);
    end
    for (int i = 1; i < 10; i++) begin
      tick();
      checks++;
      if (src !== 2'b01 || hex_out !== 32'h50) begin
        errors++;
        $display("FAIL ovl_hold cycle %0d: src=%b hex=%h, want src=01 hex=50", i, src, hex_out);
      end
    end
    tick();
    checks++;
    if (src !== 2'b00 || ovl_active !== 1'b0 || hex_out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL ovl_expire: src=%b act=%b hex=%h, want src=00 act=0 hex=12345678", src, ovl_active, hex_out);
    end
  endtask

  task automatic test_overlay_retrigger;
    ovl_hex = 32'h0000_0050; ovl_req = 1'b1;
    tick();
    ovl_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 7) begin
        ovl_req = 1'b1; ovl_hex = 32'h0000_0077;
      end
      tick();
      ovl_req = 1'b0;
      checks++;
      if (src !== 2'b01 || hex_out !== ((i >= 7) ? 32'h77 : 32'h50)) begin
        errors++;
        $display("FAIL ovl_retrigger cycle %0d: src=%b hex=%h, want src=01 hex=%h",
                 i, src, hex_out, (i >= 7) ? 32'h77 : 32'h50);
      end
    end
    tick();
    checks++;
    if (src !== 2'b00 || ovl_active !== 1'b0) begin
      errors++;
      $display("FAIL ovl_retrigger_end: src=%b act=%b, want src=00 act=0", src, ovl_active);
    end
  endtask

  task automatic test_overlay_expiry_req;
    ovl_hex = 32'h0000_0011; ovl_req = 1'b1;
    tick();
    ovl_req = 1'b0;
    repeat (9) tick();
    ovl_req = 1'b1; ovl_hex = 32'h0000_0022;
    tick();
    ovl_req = 1'b0;
    checks++;
    if (ovl_active !== 1'b1 || src !== 2'b01 || hex_out !== 32'h22) begin
      errors++;
      $display("FAIL ovl_expiry_req: act=%b src=%b hex=%h, want act=1 src=01 hex=22", ovl_active, src, hex_out);
    end
    for (int i = 1; i < 10; i++) begin
      tick();
      checks++;
      if (src !== 2'b01 || ovl_active !== 1'b1) begin
        errors++;
        $display("FAIL ovl_reload cycle %0d: src=%b act=%b, want src=01 act=1", i, src, ovl_active);
      end
    end
    tick();
    checks++;
    if (src !== 2'b00 || ovl_active !== 1'b0) begin
      errors++;
      $display("FAIL ovl_reload_end: src=%b act=%b, want src=00 act=0", src, ovl_active);
    end
  endtask

  task automatic test_alert_blink;
    logic [7:0] exp_en;
    alert_hex = 32'hEEEE_0001; alert_req = 1'b1;
    tick();
    alert_req = 1'b0;
    checks++;
    if (src !== 2'b10 || hex_out !== 32'hEEEE_0001 || dp_out !== 8'h00 || digit_en !== 8'h00) begin
      errors++;
      $display("FAIL alert_start: src=%b hex=%h dp=%h en=%h, want src=10 hex=eeee0001 dp=00 en=00",
               src, hex_out, dp_out, digit_en);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp_en = (((j / 4) % 2) == 1) ? 8'hFF : 8'h00;
      checks++;
      if (src !== 2'b10 || digit_en !== exp_en) begin
        errors++;
        $display("FAIL alert_blink cycle %0d: src=%b en=%h, want src=10 en=%h", j, src, digit_en, exp_en);
      end
    end
    // Restart while in the off phase: blink must come back on immediately.
    alert_hex = 32'hDEAD_0002; alert_req = 1'b1;
    tick();
    alert_req = 1'b0;
    checks++;
    if (hex_out !== 32'hDEAD_0002 || digit_en !== 8'h00) begin
      errors++;
      $display("FAIL alert_restart: hex=%h en=%h, want hex=dead0002 en=00", hex_out, digit_en);
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      exp_en = (j == 4) ? 8'hFF : 8'h00;
      checks++;
      if (digit_en !== exp_en) begin
        errors++;
        $display("FAIL alert_restart_blink cycle %0d: en=%h, want en=%h", j, digit_en, exp_en);
      end
    end
    alert_clr = 1'b1;
    tick();
    alert_clr = 1'b0;
    checks++;
    if (src !== 2'b00 || hex_out !== 32'h1234_5678 || digit_en !== 8'h00) begin
      errors++;
      $display("FAIL alert_clear: src=%b hex=%h en=%h, want src=00 hex=12345678 en=00", src, hex_out, digit_en);
    end
  endtask

  task automatic test_alert_over_overlay;
    ovl_hex = 32'h0000_0033; ovl_req = 1'b1;
    tick();
    ovl_req = 1'b0;
    repeat (2) tick();
    alert_hex = 32'hAAAA_0003; alert_req = 1'b1;
    tick();
    alert_req = 1'b0;
    checks++;
    if (src !== 2'b10) begin
      errors++;
      $display("FAIL alert_over_ovl_enter: src=%b, want 10", src);
    end
    repeat (2) tick();
    alert_clr = 1'b1;
    tick();
    alert_clr = 1'b0;
    checks++;
    if (src !== 2'b01 || hex_out !== 32'h33) begin
      errors++;
      $display("FAIL alert_to_ovl: src=%b hex=%h, want src=01 hex=33", src, hex_out);
    end
    repeat (3) tick();
    checks++;
    if (src !== 2'b01) begin
      errors++;
      $display("FAIL alert_to_ovl_hold: src=%b, want 01", src);
    end
    tick();
    checks++;
    if (src !== 2'b00) begin
      errors++;
      $display("FAIL alert_to_ovl_expire: src=%b, want 00", src);
    end
    // Late clear: overlay has already expired in the background.
    ovl_req = 1'b1;
    tick();
    ovl_req = 1'b0;
    repeat (2) tick();
    alert_req = 1'b1;
    tick();
    alert_req = 1'b0;
    repeat (9) tick();
    alert_clr = 1'b1;
    tick();
    alert_clr = 1'b0;
    checks++;
    if (src !== 2'b00 || ovl_active !== 1'b0) begin
      errors++;
      $display("FAIL alert_late_clear: src=%b act=%b, want src=00 act=0", src, ovl_active);
    end
  endtask

  task automatic test_simultaneous;
    alert_hex = 32'h5555_0004; alert_req = 1'b1; alert_clr = 1'b1;
    tick();
    alert_req = 1'b0; alert_clr = 1'b0;
    checks++;
    if (src !== 2'b10 || hex_out !== 32'h5555_0004) begin
      errors++;
      $display("FAIL req_clr_from_base: src=%b hex=%h, want src=10 hex=55550004", src, hex_out);
    end
    repeat (5) tick();
    alert_req = 1'b1; alert_clr = 1'b1;
    tick();
    alert_req = 1'b0; alert_clr = 1'b0;
    checks++;
    if (src !== 2'b10 || digit_en !== 8'h00) begin
      errors++;
      $display("FAIL req_clr_in_alert: src=%b en=%h, want src=10 en=00", src, digit_en);
    end
    alert_clr = 1'b1;
    tick();
    alert_clr = 1'b0;
    ovl_req = 1'b1;
    tick();
    ovl_req = 1'b0;
    alert_clr = 1'b1;
    tick();
    alert_clr = 1'b0;
    checks++;
    if (src !== 2'b01) begin
      errors++;
      $display("FAIL clr_outside_alert: src=%b, want 01", src);
    end
    repeat (9) tick();
  endtask

  task automatic test_reset_mid;
    ovl_req = 1'b1;
    tick();
    ovl_req = 1'b0;
    alert_req = 1'b1;
    tick();
    alert_req = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (src !== 2'b00 || ovl_active !== 1'b0 || digit_en !== 8'hFF || hex_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: src=%b act=%b en=%h hex=%h, want src=00 act=0 en=ff hex=0",
               src, ovl_active, digit_en, hex_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (src !== 2'b00 || hex_out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_mid_release: src=%b hex=%h, want src=00 hex=12345678", src, hex_out);
    end
  endtask

  task automatic test_lzb;
    logic [7:0] exp_a, exp_b, exp_c, exp_d;
`ifdef DISPLAY_ARB_LZB_EN
    exp_a = 8'hF8; exp_b = 8'hFE; exp_c = 8'hE0; exp_d = 8'hF9;
`else
    exp_a = 8'h00; exp_b = 8'h00; exp_c = 8'h00; exp_d = 8'h01;
`endif
    base_hex = 32'h0000_0305; base_dp = 8'h00; base_en = 8'h00;
    tick();
    checks++;
    if (digit_en !== exp_a) begin
      errors++;
      $display("FAIL lzb_0305: en=%h, want %h", digit_en, exp_a);
    end
    base_hex = 32'h0;
    tick();
    checks++;
    if (digit_en !== exp_b) begin
      errors++;
      $display("FAIL lzb_zero: en=%h, want %h", digit_en, exp_b);
    end
    base_hex = 32'h0000_0305; base_dp = 8'h10;
    tick();
    checks++;
    if (digit_en !== exp_c || dp_out !== 8'h10) begin
      errors++;
      $display("FAIL lzb_dp_stop: en=%h dp=%h, want en=%h dp=10", digit_en, dp_out, exp_c);
    end
    base_dp = 8'h00; base_en = 8'h01;
    tick();
    checks++;
    if (digit_en !== exp_d) begin
      errors++;
      $display("FAIL lzb_or_en: en=%h, want %h", digit_en, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_overlay_hold();
    test_overlay_retrigger();
    test_overlay_expiry_req();
    test_alert_blink();
    test_alert_over_overlay();
    test_simultaneous();
    test_reset_mid();
    test_lzb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want completion before 200000 ns");
    $fatal(1);
  end

endmodule
